// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_pkg;

   localparam int unsigned INST_BYTES   = 4;
   localparam int unsigned ISSUE_IDX_W  = 3;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   // Reset level for the active-low reset used by this stage.
   localparam logic        RST_ACTIVE_N = 1'b0;

   typedef logic [ISSUE_IDX_W-1:0] issue_idx_t;
   typedef logic [1:0]             lane_t;

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide shared memory port as seen by the fetch stage.
interface if_fetch_if #(
   parameter int unsigned ADDR_W = 32
);

   logic [ADDR_W-1:0] mem_a_o;
   logic              mem_rd_o;
   logic              mem_busy_i;
   logic [7:0]        mem_din_i;

   modport master (output mem_a_o, mem_rd_o, input mem_busy_i, mem_din_i);
   modport slave  (input mem_a_o, mem_rd_o, output mem_busy_i, mem_din_i);

endinterface

// File: rtl/if_byte_asm.sv
// Assembles fetched bytes into a little-endian word and parks one finished
// word (with its PC) while the presented instruction is stalled.
module if_byte_asm
   import if_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              cap_i,
   input  lane_t             lane_i,
   input  logic [7:0]        din_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              park_i,
   input  logic              pop_i,
   output logic              done_o,
   output logic [31:0]       word_o,
   output logic [31:0]       asm_o,
   output logic              asm_full_o,
   output logic [ADDR_W-1:0] saved_pc_o
);

   logic [31:0]       asm_q;
   logic              full_q;
   logic [ADDR_W-1:0] saved_pc_q;

   assign done_o     = cap_i & (lane_i == 2'd3);
   assign word_o     = {din_i, asm_q[23:0]};
   assign asm_o      = asm_q;
   assign asm_full_o = full_q;
   assign saved_pc_o = saved_pc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE_N) begin
         asm_q      <= '0;
         full_q     <= 1'b0;
         saved_pc_q <= '0;
      end else if (flush_i) begin
         // In-flight byte is dropped; parked word is stale after a redirect.
         full_q <= 1'b0;
      end else begin
         if (cap_i) asm_q[{lane_i, 3'b000} +: 8] <= din_i;
         if (done_o && park_i) begin
            full_q     <= 1'b1;
            saved_pc_q <= pc_i;
         end else if (pop_i) begin
            full_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/if_fetch.sv
// RV32I fetch stage: issues four byte reads per instruction, assembles the
// word and presents {pc, inst} to IF/ID, honouring branch, stall and busy.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int unsigned      ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   if_fetch_if.master        mem,
   output logic [ADDR_W-1:0] pc_o,
   output logic [31:0]       inst_o,
   output logic              inst_valid_o,
   output logic              stallreq_o
);

   logic [ADDR_W-1:0] fetch_pc_q;
   issue_idx_t        issue_idx_q;
   logic              rd_pend_q;
   lane_t             rd_lane_q;

   logic              fetch_rd;
   logic              done;
   logic              park;
   logic              consume;
   logic [31:0]       word;
   logic [31:0]       asm_word;
   logic              asm_full;
   logic [ADDR_W-1:0] saved_pc;

   assign fetch_rd = rst & ~branch_flag_i & ~mem.mem_busy_i
                   & (issue_idx_q < ISSUE_IDX_W'(INST_BYTES)) & ~asm_full
                   & ~((issue_idx_q == '0) & rd_pend_q);

   assign mem.mem_rd_o = fetch_rd;
   assign mem.mem_a_o  = fetch_pc_q + ADDR_W'(issue_idx_q);

   assign park       = inst_valid_o & stall_i;
   assign consume    = inst_valid_o & ~stall_i;
   assign stallreq_o = ~inst_valid_o;

   if_byte_asm #(
      .ADDR_W (ADDR_W)
   ) u_asm (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (branch_flag_i),
      .cap_i      (rd_pend_q),
      .lane_i     (rd_lane_q),
      .din_i      (mem.mem_din_i),
      .pc_i       (fetch_pc_q),
      .park_i     (park),
      .pop_i      (consume),
      .done_o     (done),
      .word_o     (word),
      .asm_o      (asm_word),
      .asm_full_o (asm_full),
      .saved_pc_o (saved_pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE_N) begin
         fetch_pc_q   <= RESET_PC;
         issue_idx_q  <= '0;
         rd_pend_q    <= 1'b0;
         rd_lane_q    <= '0;
         pc_o         <= '0;
         inst_o       <= '0;
         inst_valid_o <= 1'b0;
      end else if (branch_flag_i) begin
         fetch_pc_q   <= branch_target_i;
         issue_idx_q  <= '0;
         rd_pend_q    <= 1'b0;
         inst_valid_o <= 1'b0;
      end else begin
         rd_pend_q <= fetch_rd;
         if (fetch_rd) begin
            rd_lane_q   <= issue_idx_q[1:0];
            issue_idx_q <= issue_idx_q + issue_idx_t'(1);
         end
         if (done) begin
            fetch_pc_q  <= fetch_pc_q + ADDR_W'(INST_BYTES);
            issue_idx_q <= '0;
         end
         // A fresh word goes straight out unless the current one is held.
         if (done && !park) begin
            pc_o         <= fetch_pc_q;
            inst_o       <= word;
            inst_valid_o <= 1'b1;
         end else if (consume) begin
            if (asm_full) begin
               pc_o   <= saved_pc;
               inst_o <= asm_word;
            end else begin
               inst_valid_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage of the RV32I pipeline.
- Generates the PC and reads four bytes per instruction over the shared byte-wide memory port.
- Assembles each 32-bit little-endian instruction and presents {pc, inst} to the IF/ID register, which feeds the decode stage.
- Handles EX-stage branch redirects, downstream stalls and memory-port arbitration.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
ADDR_W, 32, PC and memory address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
stall_i  in  1  downstream cannot accept; hold presented instruction
branch_flag_i  in  1  redirect request from EX
branch_target_i  in  ADDR_W  redirect PC
mem_busy_i  in  1  memory port granted to data access this cycle; no fetch read may issue
mem_din_i  in  8  read byte, valid one cycle after its read was issued
mem_a_o  out  ADDR_W  byte address of fetch read
mem_rd_o  out  1  fetch read issued this cycle
pc_o  out  ADDR_W  PC of presented instruction
inst_o  out  32  presented instruction
inst_valid_o  out  1  pc_o/inst_o valid
stallreq_o  out  1  fetch has no instruction ready; to pipeline ctrl

Behaviour:
Interface and reset:
- One clock; reset is asynchronous and active-low.
- While rst=0: fetch_pc=RESET_PC, issue_idx=0, no pending read, asm_full=0.
- While rst=0: pc_o=0, inst_o=0, inst_valid_o=0, mem_rd_o=0, mem_a_o=RESET_PC, stallreq_o=1.

State:
- fetch_pc, issue_idx[2:0] (0..4), rd_pend, rd_lane[1:0], asm[31:0], asm_full.
- Output registers: pc_o, inst_o, inst_valid_o.

Read issue:
- mem_rd_o = rst & !branch_flag_i & !mem_busy_i & issue_idx<4 & !asm_full & !(issue_idx==0 & rd_pend).
- mem_a_o = fetch_pc + issue_idx (combinational).
- A cycle with mem_rd_o=1 sets rd_pend=1, rd_lane=issue_idx and increments issue_idx.
- If mem_busy_i=1, issue_idx holds; retry next cycle.

Byte capture:
- Cycle after an issue: asm[8*rd_lane+:8] <= mem_din_i.
- Lane 0 = bits 7:0 (little-endian).
- rd_pend clears unless a new read was issued in the same cycle.

Completion (lane 3 captured):
- Word = {mem_din_i, asm[23:0]}.
- If inst_valid_o=0 or stall_i=0: load inst_o=word, pc_o=fetch_pc, inst_valid_o=1.
- Otherwise: asm_full=1, and the word waits.
- In both cases: fetch_pc += 4, issue_idx=0.

Output consumption:
- The presented instruction is consumed on any cycle with inst_valid_o=1 and stall_i=0.
- On consumption, if asm_full: load inst_o=asm and pc_o=its PC (held in saved_pc), clear asm_full, inst_valid_o stays 1.
- On consumption, if not asm_full: inst_valid_o=0.
- stall_i=1 holds pc_o/inst_o/inst_valid_o unchanged.

Throughput:
- 5 cycles per instruction with no stall/busy: reads in cycles 0–3, capture in cycle 4.
- Byte 0 of the next instruction issues in cycle 5.

stallreq_o:
- stallreq_o = !inst_valid_o.

Branch (highest priority, overrides stall_i and completion):
- fetch_pc <= branch_target_i, issue_idx=0, rd_pend=0 (in-flight byte discarded), asm_full=0, inst_valid_o=0.
- No read issues in the redirect cycle.
- Fetch restarts at the target the next cycle.
- branch_target_i needs no alignment; bytes target..target+3 are read.

Wrap-around:
- fetch_pc + issue_idx and fetch_pc + 4 wrap modulo 2^ADDR_W.

Reset mid-fetch:
- Aborts immediately; in-flight data ignored.

Decomposition:
- Shared defines file gains INST_BYTES (4), the ISSUE_IDX width and RESET_PC default.
- The existing RstEnable-style polarity macro gains an active-low variant used here.
- One natural sub-module: if_byte_asm, holding the lane capture, asm/asm_full and saved_pc skid.
- The top keeps PC, issue control and branch priority.

Test Plan:
- Reset release, memory at 0 = 93 00 50 00 → reads to addresses 0,1,2,3 in cycles 0–3; cycle 5 shows pc_o=0, inst_o=32'h00500093, inst_valid_o=1, stallreq_o=0.
- Consecutive words 0x00500093, 0x00100113, stall_i=0 → pc_o 0 then 4; instructions every 5 cycles; no byte mis-lane.
- mem_busy_i=1 for 3 cycles while issue_idx=2 → mem_rd_o=0 for those cycles, address 2 reissued after; inst_o still correct, completion delayed 3 cycles.
- stall_i held 12 cycles after first valid → pc_o/inst_o frozen; second word in asm_full; on stall release pc_o=4 next cycle with no gap, then no reads until consumed.
- branch_flag_i=1, target 32'h100 with byte 2 in flight → inst_valid_o=0, next read address 0x100; stale byte never appears; branch with stall_i=1 still redirects.
- rst pulsed low mid-fetch (issue_idx=3) → all outputs 0 immediately; after release fetch restarts at RESET_PC.
